param_updown_counter: RTL and testbench

- Parametrised successor to the team's mod-14 synchronous loadable up/down counter.
- Width, modulus and step size are generic.
- Adds count enable, a wrap/saturate mode, a terminal-count flag, an overflow/underflow pulse and an illegal-load flag.
- Sits in the counter datapath; drivable by the existing counter_if-style bench once the extra signals are added.

---
 rtl/counter_pkg.sv | 22 ++
 rtl/counter_next_calc.sv | 54 +++++
 rtl/param_updown_counter.sv | 84 ++++++++
 tb/tb_param_updown_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter family.
package counter_pkg;

    localparam int COUNTER_WIDTH   = 4;
    localparam int COUNTER_MODULUS = 14;

    // Overflow behaviour selected by the SATURATE parameter.
    typedef enum logic {
        CNT_WRAP     = 1'b0,
        CNT_SATURATE = 1'b1
    } cnt_mode_e;

    // True when the parameter set describes a buildable counter.
    // The upper width bound keeps the shift below within int range.
    function automatic bit counter_params_ok(int width, int modulus, int step, int saturate);
        return (width >= 1) && (width <= 30) &&
               (modulus >= 2) && (modulus <= (1 << width)) &&
               (step >= 1) && (step <= modulus - 1) &&
               ((saturate == 0) || (saturate == 1));
    endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count for one enabled step, with boundary-crossing flag.
// All arithmetic is one bit wider than the count so sums never alias.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH    = COUNTER_WIDTH,
    parameter int MODULUS  = COUNTER_MODULUS,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_up_down,
    output logic [WIDTH-1:0] o_next_count,
    output logic             o_crossed
);

    localparam cnt_mode_e      MODE    = (SATURATE != 0) ? CNT_SATURATE : CNT_WRAP;
    localparam logic [WIDTH:0] MOD_W   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] STEP_W  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MAX_W   = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] BACK_W  = (WIDTH+1)'(MODULUS - STEP);

    logic [WIDTH:0] w_count_ext;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_next;

    assign w_count_ext = {1'b0, i_count};
    assign w_sum       = w_count_ext + STEP_W;

    // Select the stepped value, wrapped or clamped when a limit is crossed.
    always_comb begin
        w_next    = w_count_ext;
        o_crossed = 1'b0;
        if (i_up_down) begin
            if (w_sum <= MAX_W) begin
                w_next = w_sum;
            end else begin
                o_crossed = 1'b1;
                w_next    = (MODE == CNT_SATURATE) ? MAX_W : (w_sum - MOD_W);
            end
        end else begin
            if (w_count_ext >= STEP_W) begin
                w_next = w_count_ext - STEP_W;
            end else begin
                o_crossed = 1'b1;
                w_next    = (MODE == CNT_SATURATE) ? '0 : (w_count_ext + BACK_W);
            end
        end
    end

    // Result is always below MODULUS, so it fits in WIDTH bits.
    assign o_next_count = WIDTH'(w_next);

endmodule

// File: rtl/param_updown_counter.sv
// Loadable modulo up/down counter with enable, wrap/saturate mode,
// terminal count, overflow pulse and illegal-load pulse.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = COUNTER_WIDTH,
    parameter int MODULUS  = COUNTER_MODULUS,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_up_down,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data_in,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_ovf,
    output logic             o_load_err
);

    if (!counter_params_ok(WIDTH, MODULUS, STEP, SATURATE)) begin : g_bad_params
        $error("param_updown_counter: illegal WIDTH/MODULUS/STEP/SATURATE combination");
    end

    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             r_load_err;
    logic [WIDTH-1:0] w_next_count;
    logic             w_crossed;
    logic             w_load_ok;

    counter_next_calc #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .STEP     (STEP),
        .SATURATE (SATURATE)
    ) u_next_calc (
        .i_count      (r_count),
        .i_up_down    (i_up_down),
        .o_next_count (w_next_count),
        .o_crossed    (w_crossed)
    );

    assign w_load_ok = ({1'b0, i_data_in} < MOD_W);

    // Count register and event pulses: reset > load > enabled step > hold.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_load_err <= 1'b0;
        end else if (i_load) begin
            r_ovf <= 1'b0;
            if (w_load_ok) begin
                r_count    <= i_data_in;
                r_load_err <= 1'b0;
            end else begin
                r_load_err <= 1'b1;
            end
        end else if (i_enable) begin
            r_count    <= w_next_count;
            r_ovf      <= w_crossed;
            r_load_err <= 1'b0;
        end else begin
            r_ovf      <= 1'b0;
            r_load_err <= 1'b0;
        end
    end

    // Terminal count follows the live direction with no register delay.
    always_comb begin
        o_tc = i_up_down ? (r_count == MAX_C) : (r_count == '0);
    end

    assign o_count    = r_count;
    assign o_ovf      = r_ovf;
    assign o_load_err = r_load_err;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: three instances share stimulus,
// each scenario checks the instance whose parameters it targets.
module tb_param_updown_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [3:0] data_in;

    logic [3:0] cnt_def, cnt_sat, cnt_st3;
    logic       tc_def,  tc_sat,  tc_st3;
    logic       ovf_def, ovf_sat, ovf_st3;
    logic       le_def,  le_sat,  le_st3;

    int n_checks = 0;
    int n_fail   = 0;

    param_updown_counter u_def (
        .i_clock (clk), .i_reset (reset), .i_enable (enable), .i_up_down (up_down),
        .i_load (load), .i_data_in (data_in),
        .o_count (cnt_def), .o_tc (tc_def), .o_ovf (ovf_def), .o_load_err (le_def)
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .STEP(1), .SATURATE(1)) u_sat (
        .i_clock (clk), .i_reset (reset), .i_enable (enable), .i_up_down (up_down),
        .i_load (load), .i_data_in (data_in),
        .o_count (cnt_sat), .o_tc (tc_sat), .o_ovf (ovf_sat), .o_load_err (le_sat)
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(14), .STEP(3), .SATURATE(0)) u_st3 (
        .i_clock (clk), .i_reset (reset), .i_enable (enable), .i_up_down (up_down),
        .i_load (load), .i_data_in (data_in),
        .o_count (cnt_st3), .o_tc (tc_st3), .o_ovf (ovf_st3), .o_load_err (le_st3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic en, input logic ud,
                         input logic ld, input logic [3:0] d);
        reset   = rst;
        enable  = en;
        up_down = ud;
        load    = ld;
        data_in = d;
    endtask

    initial begin
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
        tick();
        check_val("rst_cnt_def", cnt_def, 0);
        check_val("rst_cnt_sat", cnt_sat, 0);
        check_val("rst_cnt_st3", cnt_st3, 0);
        check_val("rst_ovf_def", ovf_def, 0);
        check_val("rst_lerr_def", le_def, 0);

        // 1: reset mid-count, then resume from 0
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
        tick();
        check_val("t1_load5", cnt_def, 5);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        check_val("t1_up6", cnt_def, 6);
        tick();
        check_val("t1_up7", cnt_def, 7);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        check_val("t1_rst_cnt", cnt_def, 0);
        check_val("t1_rst_ovf", ovf_def, 0);
        check_val("t1_rst_lerr", le_def, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        check_val("t1_resume", cnt_def, 1);

        // 2: wrap up from 13
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd13);
        tick();
        check_val("t2_load13", cnt_def, 13);
        check_val("t2_tc_at13", tc_def, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        check_val("t2_wrap_cnt", cnt_def, 0);
        check_val("t2_wrap_ovf", ovf_def, 1);
        check_val("t2_tc_at0_up", tc_def, 0);
        tick();
        check_val("t2_next_cnt", cnt_def, 1);
        check_val("t2_ovf_drop", ovf_def, 0);

        // 3: wrap down from 0
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        check_val("t3_load0", cnt_def, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        #1;
        check_val("t3_tc_down0", tc_def, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        check_val("t3_wrap_cnt", cnt_def, 13);
        check_val("t3_wrap_ovf", ovf_def, 1);
        check_val("t3_tc_13_down", tc_def, 0);
        tick();
        check_val("t3_next_cnt", cnt_def, 12);
        check_val("t3_ovf_drop", ovf_def, 0);

        // 4: illegal load, then load beats enable
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd6);
        tick();
        check_val("t4_load6", cnt_def, 6);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd14);
        tick();
        check_val("t4_bad_cnt", cnt_def, 6);
        check_val("t4_bad_lerr", le_def, 1);
        check_val("t4_bad_ovf", ovf_def, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        check_val("t4_lerr_drop", le_def, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
        tick();
        check_val("t4_load_wins", cnt_def, 9);
        check_val("t4_load_ovf", ovf_def, 0);
        check_val("t4_load_lerr", le_def, 0);

        // 5: saturate, MODULUS=10
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd8);
        tick();
        check_val("t5_load8", cnt_sat, 8);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        check_val("t5_c1_cnt", cnt_sat, 9);
        check_val("t5_c1_ovf", ovf_sat, 0);
        tick();
        check_val("t5_c2_cnt", cnt_sat, 9);
        check_val("t5_c2_ovf", ovf_sat, 1);
        tick();
        check_val("t5_c3_cnt", cnt_sat, 9);
        check_val("t5_c3_ovf", ovf_sat, 1);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd10);
        tick();
        check_val("t5_load10_cnt", cnt_sat, 9);
        check_val("t5_load10_lerr", le_sat, 1);
        check_val("t5_load10_ovf", ovf_sat, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        check_val("t5_load0", cnt_sat, 0);
        check_val("t5_load0_lerr", le_sat, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        check_val("t5_down_cnt", cnt_sat, 0);
        check_val("t5_down_ovf", ovf_sat, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        check_val("t5_hold_ovf", ovf_sat, 0);

        // 6: STEP=3 wrap both directions, then hold
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd12);
        tick();
        check_val("t6_load12", cnt_st3, 12);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        check_val("t6_up_cnt", cnt_st3, 1);
        check_val("t6_up_ovf", ovf_st3, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        check_val("t6_down_cnt", cnt_st3, 12);
        check_val("t6_down_ovf", ovf_st3, 1);
        tick();
        check_val("t6_down2_cnt", cnt_st3, 9);
        check_val("t6_down2_ovf", ovf_st3, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        check_val("t6_hold_cnt", cnt_st3, 9);
        check_val("t6_hold_ovf", ovf_st3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
